lsu_mem_bridge: RTL and testbench
=================================

Name: lsu_mem_bridge

Overview:
Load/store bridge between the processor's data port and the word-wide data RAM. Accepts one load or store at a time, using RISC-V funct3 sizing (LB/LH/LW/LBU/LHU, SB/SH/SW). Sub-word stores are done as read-modify-write on the word RAM, loads are sign- or zero-extended, and the core is stalled until the access completes. Allows the data RAM to become synchronous with configurable read latency.

Parameters:
ADDR_W, 7, byte-address width decoded into the RAM; word index = cpu_addr[ADDR_W-1:2]
MEM_LAT, 0, RAM read latency in edges (0..3); 0 = combinational read

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  access request; held by core until cpu_ack
cpu_we  in  1  1 = store, 0 = load
cpu_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, right-aligned
cpu_rdata  out  32  extended load result, registered
cpu_stall  out  1  core must hold state
cpu_ack  out  1  one-cycle completion pulse
mem_addr  out  ADDR_W-2  RAM word index, registered
mem_re  out  1  RAM read strobe, registered
mem_we  out  1  RAM write strobe, registered
mem_wdata  out  32  RAM write word, registered
mem_rdata  in  32  RAM read word

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0. Asserting reset mid-access drops mem_we/mem_re at once. No partial write occurs.
- States: IDLE, RD_WAIT, RMW_WAIT, WR, ACK.
- Edge numbering: E0 = edge at which IDLE samples cpu_req=1. IDLE latches addr, size, we, wdata.
- Load: at E0, mem_re=1, mem_addr set, cnt=MEM_LAT, go to RD_WAIT.
  - mem_re drops at E1.
  - mem_rdata is sampled at E(1+MEM_LAT); lane extraction is registered into cpu_rdata; go to ACK.
- Store word (size 010): at E0, mem_we=1 and mem_wdata=cpu_wdata, go to WR. The RAM writes at E1; mem_we drops; go to ACK.
- Store byte/half: at E0, mem_re=1, go to RMW_WAIT.
  - At E(1+MEM_LAT), merge and go to WR with mem_we=1.
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces half lane addr[1] with wdata[15:0].
- Load extraction:
  - B: sign-extend byte lane addr[1:0]; BU: zero-extend it.
  - H: sign-extend half lane addr[1]; HU: zero-extend it.
  - W: full word.
- Unlisted funct3 (011, 110, 111): treated as word.
- ACK: cpu_ack=1 for exactly one cycle, then IDLE. cpu_req is NOT sampled at the ACK→IDLE edge. The next request is accepted at the following edge.
- Latency (ack-high cycle follows):
  - load: E(1+MEM_LAT)
  - SW: E1
  - SB/SH: E(2+MEM_LAT)
- cpu_stall (combinational) = (state in RD_WAIT/RMW_WAIT/WR) OR (state==IDLE AND cpu_req). It is 0 in ACK.
- cpu_rdata holds the last load result; stores never change it.
- Misalignment without macro: word ignores addr[1:0]; half ignores addr[0].
- Address bits above ADDR_W-1 are ignored (aliasing).
- cpu_req dropped mid-access: the access still completes and acks.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: adds output cpu_err (1 bit, reset 0). A misaligned access is one where H/HU has addr[0]=1, or W has addr[1:0]≠0. For such an access:
  - no mem_re or mem_we is issued;
  - IDLE goes directly to ACK at E0;
  - cpu_err=1 with cpu_ack;
  - cpu_rdata is left unchanged.
- Undefined: no cpu_err port; misaligned accesses follow the silent low-bit masking above.

Test Plan:
1. Assert reset_n=0 during RD_WAIT (MEM_LAT=2) → all outputs 0 immediately; no mem_we pulse. After release, IDLE with cpu_stall=0.
2. MEM_LAT=1, SW 0x08 ← 0xDEADBEEF → single mem_we cycle, mem_addr=2, mem_wdata=0xDEADBEEF, ack after E1. Then LW 0x08 → cpu_rdata=0xDEADBEEF, ack after E2.
3. SB 0x09 ← 0x000000AA → mem_wdata=0xDEADAAEF, ack after E3. LB 0x09 → 0xFFFFFFAA; LBU 0x09 → 0x000000AA.
4. SH 0x0A ← 0x00001234 → word becomes 0x1234AAEF. LH 0x0A → 0x00001234; LH 0x08 → 0xFFFFAAEF; LHU 0x08 → 0x0000AAEF.
5. Back-to-back LW/SW/LB with a new request presented in the cycle after ack, MEM_LAT ∈ {0, 3} → each request accepted one edge after ACK. Latencies match the formulas; cpu_stall is low only during ack cycles.
6. With MISALIGN_TRAP_EN, LW 0x0A → no mem_re/mem_we; cpu_ack=cpu_err=1 after E0; cpu_rdata unchanged. The next aligned LW completes with cpu_err=0.

Source files
------------

// File: rtl/lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_bridge
// Description : Load/store bridge from the core data port to a word-wide RAM.
//               Byte/half stores are read-modify-write; loads are extended.
//               Optional macro MISALIGN_TRAP_EN adds cpu_err and traps
//               misaligned half/word accesses instead of masking low bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_bridge #(
  parameter int ADDR_W  = 7,
  parameter int MEM_LAT = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_size,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_ack,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              cpu_err
`endif
);

  localparam logic [1:0] C_LAT = 2'(MEM_LAT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RMW_WAIT = 3'd2,
    WR       = 3'd3,
    ACK      = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_cnt, w_cnt_nxt;
  logic [1:0]        r_lane, w_lane_nxt;
  logic [2:0]        r_size, w_size_nxt;
  logic [15:0]       r_wdata, w_wdata_nxt;
  logic [ADDR_W-3:0] w_mem_addr_nxt;
  logic              w_mem_re_nxt;
  logic              w_mem_we_nxt;
  logic [31:0]       w_mem_wdata_nxt;
  logic [31:0]       w_rdata_nxt;
  logic              w_trap;
  logic              w_unused_addr;

  // Upper address bits simply alias onto the RAM.
  assign w_unused_addr = &{1'b0, cpu_addr[31:ADDR_W]};

  // Lane extraction with sign/zero extension; size[1] set means full word.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  lane,
                                          input logic [2:0]  size);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size[1:0])
      2'b00:   return size[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return size[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word,
                                        input logic [1:0]  lane,
                                        input logic [1:0]  size,
                                        input logic [15:0] wdata);
    logic [31:0] res;
    res = word;
    if (size == 2'b00) begin
      res[{lane, 3'b000} +: 8] = wdata[7:0];
    end else if (lane[1]) begin
      res[31:16] = wdata;
    end else begin
      res[15:0] = wdata;
    end
    return res;
  endfunction

`ifdef MISALIGN_TRAP_EN
  logic r_err;

  assign w_trap = cpu_size[1] ? (cpu_addr[1:0] != 2'b00)
                              : (cpu_size[0] & cpu_addr[0]);

  // Error flag rides alongside the ack cycle only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (r_state == IDLE) begin
      r_err <= cpu_req & w_trap;
    end else if (r_state == ACK) begin
      r_err <= 1'b0;
    end
  end

  assign cpu_err = r_err;
`else
  assign w_trap = 1'b0;
`endif

  assign cpu_ack   = (r_state == ACK);
  assign cpu_stall = reset_n & ((r_state == RD_WAIT) || (r_state == RMW_WAIT) ||
                                (r_state == WR) || ((r_state == IDLE) && cpu_req));

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_lane_nxt      = r_lane;
    w_size_nxt      = r_size;
    w_wdata_nxt     = r_wdata;
    w_mem_addr_nxt  = mem_addr;
    w_mem_re_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_wdata_nxt = mem_wdata;
    w_rdata_nxt     = cpu_rdata;
    case (r_state)
      IDLE: begin
        if (cpu_req) begin
          if (w_trap) begin
            w_state_nxt = ACK;
          end else begin
            w_lane_nxt     = cpu_addr[1:0];
            w_size_nxt     = cpu_size;
            w_wdata_nxt    = cpu_wdata[15:0];
            w_mem_addr_nxt = cpu_addr[ADDR_W-1:2];
            w_cnt_nxt      = C_LAT;
            if (cpu_we && cpu_size[1]) begin
              w_mem_we_nxt    = 1'b1;
              w_mem_wdata_nxt = cpu_wdata;
              w_state_nxt     = WR;
            end else begin
              w_mem_re_nxt = 1'b1;
              w_state_nxt  = cpu_we ? RMW_WAIT : RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_rdata_nxt = extract(mem_rdata, r_lane, r_size);
          w_state_nxt = ACK;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      RMW_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_mem_wdata_nxt = merge(mem_rdata, r_lane, r_size[1:0], r_wdata);
          w_mem_we_nxt    = 1'b1;
          w_state_nxt     = WR;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      WR:      w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_lane    <= 2'd0;
      r_size    <= 3'd0;
      r_wdata   <= 16'd0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= 32'd0;
      cpu_rdata <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lane    <= w_lane_nxt;
      r_size    <= w_size_nxt;
      r_wdata   <= w_wdata_nxt;
      mem_addr  <= w_mem_addr_nxt;
      mem_re    <= w_mem_re_nxt;
      mem_we    <= w_mem_we_nxt;
      mem_wdata <= w_mem_wdata_nxt;
      cpu_rdata <= w_rdata_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_bridge
// Description : Self-checking bench; four bridges (MEM_LAT 0..3) each on its
//               own RAM model, checked against a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_sh, we;
  logic [2:0]  size;
  logic [31:0] addr, wdata;
  int          sel;
  int          n_chk = 0;
  int          n_err = 0;

  logic        req_i   [4];
  logic [31:0] rdata_o [4];
  logic        stall_o [4];
  logic        ack_o   [4];
  logic [4:0]  maddr_o [4];
  logic        mre_o   [4];
  logic        mwe_o   [4];
  logic [31:0] mwd_o   [4];
  logic [31:0] mrd_i   [4];
  logic        err_o   [4];

  logic [31:0] model_mem [4][32];
  logic [31:0] model_rd  [4];

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int g, input int i);
    logic [31:0] v;
    v = 32'h9E3779B9 * 32'(i + 1) + 32'h01010101 * 32'(g);
    return v;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [31:0] mem  [32];
    logic [31:0] pipe [3];

    assign req_i[g] = (sel == g) ? req_sh : 1'b0;

    lsu_mem_bridge #(.ADDR_W(7), .MEM_LAT(g)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cpu_req   (req_i[g]),
      .cpu_we    (we),
      .cpu_size  (size),
      .cpu_addr  (addr),
      .cpu_wdata (wdata),
      .cpu_rdata (rdata_o[g]),
      .cpu_stall (stall_o[g]),
      .cpu_ack   (ack_o[g]),
      .mem_addr  (maddr_o[g]),
      .mem_re    (mre_o[g]),
      .mem_we    (mwe_o[g]),
      .mem_wdata (mwd_o[g]),
      .mem_rdata (mrd_i[g])
`ifdef MISALIGN_TRAP_EN
      ,
      .cpu_err   (err_o[g])
`endif
    );

`ifndef MISALIGN_TRAP_EN
    assign err_o[g] = 1'b0;
`endif

    initial begin
      for (int i = 0; i < 32; i++) mem[i] = init_word(g, i);
    end

    // RAM: write on mem_we; read captured on mem_re and delayed g edges.
    always @(posedge clk) begin
      if (mwe_o[g]) mem[maddr_o[g]] <= mwd_o[g];
      pipe[0] <= mre_o[g] ? mem[maddr_o[g]] : 32'hBAD0BAD0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end

    assign mrd_i[g] = (g == 0) ? mem[maddr_o[g]] : pipe[(g == 0) ? 0 : g - 1];
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] s);
    case (s)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int lane_shift(input logic [2:0] s, input logic [31:0] a);
    int nb;
    nb = nbytes(s);
    if (nb == 1) return 8 * int'(a[1:0]);
    if (nb == 2) return 16 * int'(a[1]);
    return 0;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [2:0] s);
    int nb;
    nb = nbytes(s);
    if (nb == 4) return 32'hFFFFFFFF;
    return 32'((64'd1 << (8 * nb)) - 64'd1);
  endfunction

  function automatic logic [31:0] load_ref(input logic [31:0] word, input logic [2:0] s,
                                           input logic [31:0] a);
    logic [31:0] v, m;
    int nb;
    nb = nbytes(s);
    m  = lane_mask(s);
    v  = (word >> lane_shift(s, a)) & m;
    if (nb < 4 && !(s == 3'd4 || s == 3'd5) && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] store_ref(input logic [31:0] word, input logic [2:0] s,
                                            input logic [31:0] a, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    m  = lane_mask(s);
    sh = lane_shift(s, a);
    return (word & ~(m << sh)) | ((d & m) << sh);
  endfunction

  function automatic logic misaligned(input logic [2:0] s, input logic [31:0] a);
    int nb;
    nb = nbytes(s);
    return (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lat=%0d: got %h expected %h", name, sel, act, exp);
    end
  endtask

  task automatic idle();
    req_sh = 1'b0;
    @(negedge clk);
  endtask

  // One access on bridge `sel`; exp_wait = idle cycles seen before acceptance.
  task automatic access(input logic a_we, input logic [2:0] a_size, input logic [31:0] a_addr,
                        input logic [31:0] a_wdata, input int exp_wait,
                        output logic [31:0] got_wd);
    int lat, k, n, nre, nwe, exp_lat, exp_nre, exp_nwe;
    logic done, trap;
    logic [4:0] idx;
    logic [31:0] exp_wd, exp_rd;
    lat  = sel;
    idx  = a_addr[6:2];
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = misaligned(a_size, a_addr);
`endif
    if (trap)                    exp_lat = 0;
    else if (!a_we)              exp_lat = 1 + lat;
    else if (nbytes(a_size) == 4) exp_lat = 1;
    else                         exp_lat = 2 + lat;
    exp_nre = (trap || (a_we && nbytes(a_size) == 4)) ? 0 : 1;
    exp_nwe = (a_we && !trap) ? 1 : 0;
    exp_wd  = store_ref(model_mem[lat][idx], a_size, a_addr, a_wdata);
    exp_rd  = (!a_we && !trap) ? load_ref(model_mem[lat][idx], a_size, a_addr) : model_rd[lat];

    req_sh = 1'b1; we = a_we; size = a_size; addr = a_addr; wdata = a_wdata;
    #1;
    k = 0;
    while (!(stall_o[sel] && !ack_o[sel]) && k < 4) begin
      @(posedge clk); @(negedge clk); #1;
      k++;
    end
    chk("accept_wait", 32'(k), 32'(exp_wait));

    n = 0; nre = 0; nwe = 0; done = 1'b0; got_wd = 32'd0;
    while (!done && n < 12) begin
      @(posedge clk); @(negedge clk); #1;
      if (mre_o[sel]) nre++;
      if (mwe_o[sel]) begin
        nwe++;
        got_wd = mwd_o[sel];
      end
      if (mre_o[sel] || mwe_o[sel]) chk("mem_addr", 32'(maddr_o[sel]), 32'(idx));
      if (ack_o[sel]) done = 1'b1;
      else begin
        chk("stall_busy", 32'(stall_o[sel]), 32'd1);
        n++;
      end
    end
    chk("ack_seen", 32'(done), 32'd1);
    chk("latency", 32'(n), 32'(exp_lat));
    chk("stall_at_ack", 32'(stall_o[sel]), 32'd0);
    chk("mem_re_cycles", 32'(nre), 32'(exp_nre));
    chk("mem_we_cycles", 32'(nwe), 32'(exp_nwe));
    if (a_we && !trap) chk("mem_wdata", got_wd, exp_wd);
    chk("cpu_rdata", rdata_o[sel], exp_rd);
`ifdef MISALIGN_TRAP_EN
    chk("cpu_err", 32'(err_o[sel]), 32'(trap));
`endif
    if (a_we && !trap) model_mem[lat][idx] = exp_wd;
    model_rd[lat] = exp_rd;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [9];
  logic [2:0] size_pool [8];

  initial begin
    logic [31:0] wd;
    int nw;
    int b2b;

    tbl[0] = '{1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000};
    tbl[1] = '{1'b0, 3'b010, 32'h08, 32'h0,        32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b1, 3'b000, 32'h09, 32'h000000AA, 32'hDEADAAEF, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 3'b000, 32'h09, 32'h0,        32'h0,        32'hFFFFFFAA};
    tbl[4] = '{1'b0, 3'b100, 32'h09, 32'h0,        32'h0,        32'h000000AA};
    tbl[5] = '{1'b1, 3'b001, 32'h0A, 32'h00001234, 32'h1234AAEF, 32'h000000AA};
    tbl[6] = '{1'b0, 3'b001, 32'h0A, 32'h0,        32'h0,        32'h00001234};
    tbl[7] = '{1'b0, 3'b001, 32'h08, 32'h0,        32'h0,        32'hFFFFAAEF};
    tbl[8] = '{1'b0, 3'b101, 32'h08, 32'h0,        32'h0,        32'h0000AAEF};
    size_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 32; i++) model_mem[g][i] = init_word(g, i);
      model_rd[g] = 32'd0;
    end

    reset_n = 1'b0; req_sh = 1'b0; we = 1'b0; size = 3'd0; addr = 32'd0; wdata = 32'd0;
    sel = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      sel = g;
      chk("rst_rdata", rdata_o[g], 32'd0);
      chk("rst_ack_stall", {30'd0, ack_o[g], stall_o[g]}, 32'd0);
      chk("rst_mem", {25'd0, maddr_o[g], mre_o[g], mwe_o[g]}, 32'd0);
      chk("rst_mem_wdata", mwd_o[g], 32'd0);
    end

    // Reset asserted while a MEM_LAT=2 load sits in RD_WAIT.
    sel = 2;
    idle();
    access(1'b1, 3'b010, 32'h10, 32'h55AA1234, 0, wd);
    idle();
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, wd);
    idle();
    req_sh = 1'b1; we = 1'b0; size = 3'b010; addr = 32'h10;
    #1;
    @(posedge clk); @(negedge clk); #1;
    chk("mid_rst_re_e0", 32'(mre_o[2]), 32'd1);
    @(posedge clk); @(negedge clk); #1;
    reset_n = 1'b0; req_sh = 1'b0;
    #1;
    chk("mid_rst_rdata", rdata_o[2], 32'd0);
    chk("mid_rst_mem_wdata", mwd_o[2], 32'd0);
    chk("mid_rst_strobes", {25'd0, maddr_o[2], mre_o[2], mwe_o[2]}, 32'd0);
    chk("mid_rst_ack_stall", {30'd0, ack_o[2], stall_o[2]}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_stall", 32'(stall_o[2]), 32'd0);
    nw = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (mwe_o[2] || mre_o[2] || ack_o[2]) nw++;
    end
    chk("post_rst_quiet", 32'(nw), 32'd0);
    for (int g = 0; g < 4; g++) model_rd[g] = 32'd0;
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, wd);

    // Directed table on MEM_LAT=1.
    sel = 1;
    idle();
    for (int i = 0; i < 9; i++) begin
      access(tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata, 0, wd);
      if (tbl[i].we) chk("tbl_mem_wdata", wd, tbl[i].exp_wd);
      chk("tbl_rdata", rdata_o[1], tbl[i].exp_rd);
      idle();
    end

    // Back-to-back LW/SW/LB, next request presented during the ack cycle.
    for (int j = 0; j < 2; j++) begin
      sel = (j == 0) ? 0 : 3;
      idle();
      access(1'b0, 3'b010, 32'h08, 32'h0, 0, wd);
      access(1'b1, 3'b010, 32'h0C, 32'hCAFEF00D, 1, wd);
      access(1'b0, 3'b000, 32'h0F, 32'h0, 1, wd);
      access(1'b0, 3'b010, 32'h0C, 32'h0, 1, wd);
      idle();
    end

`ifdef MISALIGN_TRAP_EN
    sel = 1;
    idle();
    access(1'b0, 3'b010, 32'h0A, 32'h0, 0, wd);
    access(1'b0, 3'b010, 32'h08, 32'h0, 1, wd);
    idle();
`endif

    // Randomized traffic on every latency.
    for (int g = 0; g < 4; g++) begin
      sel = g;
      idle();
      for (int i = 0; i < 40; i++) begin
        b2b = (i == 0) ? 0 : int'($urandom_range(0, 1));
        if (b2b == 0 && i != 0) idle();
        access(1'($urandom_range(0, 1)), size_pool[$urandom_range(0, 7)], $urandom,
               $urandom, b2b, wd);
      end
      idle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
